// File: rtl/locked_arb_pkg.sv
// rtl/locked_arb_pkg.sv - shared types and helpers for the locked FIFO arbiter
package locked_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int QDEPTH  = 4;

   typedef logic [1:0] req_id_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   function automatic logic [NUM_REQ-1:0] onehot4(input req_id_t id);
      return 4'b0001 << id;
   endfunction

endpackage

// File: rtl/id_fifo.sv
// rtl/id_fifo.sv - 4-deep requester-ID queue with ordered multi-push and single pop
module id_fifo
   import locked_arb_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] push_vec,
   input  logic               pop,
   output req_id_t            head,
   output logic [2:0]         count
);

   req_id_t    q   [QDEPTH];
   req_id_t    q_n [QDEPTH];
   logic [2:0] count_n;

   // Pop shifts the old head out first, so pushes land behind the survivors.
   always_comb begin
      q_n     = q;
      count_n = count;
      if (pop && count != 3'd0) begin
         for (int i = 0; i < QDEPTH - 1; i++) begin
            q_n[i] = q[i+1];
         end
         q_n[QDEPTH-1] = '0;
         count_n       = count - 3'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (push_vec[i] && count_n < 3'(QDEPTH)) begin
            q_n[count_n[1:0]] = req_id_t'(i);
            count_n           = count_n + 3'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            q[i] <= '0;
         end
         count <= '0;
      end else begin
         q     <= q_n;
         count <= count_n;
      end
   end

   assign head = q[0];

endmodule

// File: rtl/locked_queue_arbiter.sv
// rtl/locked_queue_arbiter.sv - key-locked 4-requester FIFO-ordered grant arbiter
module locked_queue_arbiter
   import locked_arb_pkg::*;
#(
   parameter int                  KEY_W       = 3,
   parameter logic [4*KEY_W-1:0]  CORRECT_KEY = 12'b101_011_110_001
)
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] request,
   input  logic [KEY_W-1:0]   keyinput,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               busy_o
);

   logic [NUM_REQ-1:0] req_r;
   logic [NUM_REQ-1:0] req_d;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] rise;
   logic [NUM_REQ-1:0] push_vec;
   logic [NUM_REQ-1:0] pop_mask;
   logic [1:0]         cnt;
   logic [2:0]         count;
   logic               pop;
   logic               key_ok;
   state_t             state;
   req_id_t            head;
   req_id_t            gid;
   req_id_t            gid_sel;

   assign rise     = req_r & ~req_d;
   assign push_vec = rise & ~pending & ~grant_o;
   assign pop      = (state == IDLE) && (count != 3'd0);
   assign pop_mask = pop ? onehot4(head) : '0;

   // A wrong slice quietly rotates the grantee to the next requester ID.
   assign key_ok  = (keyinput == CORRECT_KEY[int'(cnt)*KEY_W +: KEY_W]);
   assign gid_sel = key_ok ? head : head + 2'd1;

   id_fifo u_id_fifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .push_vec (push_vec),
      .pop      (pop),
      .head     (head),
      .count    (count)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_r   <= '0;
         req_d   <= '0;
         pending <= '0;
         cnt     <= '0;
         state   <= IDLE;
         gid     <= '0;
         grant_o <= '0;
         busy_o  <= 1'b0;
      end else begin
         req_r   <= request;
         req_d   <= req_r;
         cnt     <= cnt + 2'd1;
         pending <= (pending & ~pop_mask) | push_vec;
         case (state)
            IDLE: begin
               if (pop && req_r[gid_sel]) begin
                  gid     <= gid_sel;
                  grant_o <= onehot4(gid_sel);
                  busy_o  <= 1'b1;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (!req_r[gid]) begin
                  grant_o <= '0;
                  busy_o  <= 1'b0;
                  state   <= RELEASE;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_locked_queue_arbiter.sv
// tb/tb_locked_queue_arbiter.sv - scoreboard bench for locked_queue_arbiter
module tb_locked_queue_arbiter;

   logic       clock;
   logic       reset_n;
   logic [3:0] request;
   logic [2:0] keyinput;
   logic [3:0] grant_o;
   logic       busy_o;

   int         n_checks;
   int         n_errors;
   logic [3:0] exp_q[$];
   int         gaps[$];
   logic [3:0] prev_g;
   logic [3:0] exp_g;
   int         gap;
   logic [1:0] tb_cnt;
   logic [2:0] kslice;
   logic       key_bad;

   locked_queue_arbiter dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .request  (request),
      .keyinput (keyinput),
      .grant_o  (grant_o),
      .busy_o   (busy_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) tb_cnt <= 2'd0;
      else          tb_cnt <= tb_cnt + 2'd1;
   end

   always_comb begin
      case (tb_cnt)
         2'd0:    kslice = 3'b001;
         2'd1:    kslice = 3'b110;
         2'd2:    kslice = 3'b011;
         default: kslice = 3'b101;
      endcase
   end

   assign keyinput = key_bad ? 3'b000 : kslice;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (!reset_n) begin
         prev_g = 4'b0;
         gap    = 0;
      end else begin
         if (grant_o != 4'b0 && grant_o != prev_g) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", grant_o, 4'h0);
            end else begin
               exp_g = exp_q.pop_front();
               check("grant_order", grant_o, exp_g);
            end
            check("busy_with_grant", busy_o, 1'b1);
            gaps.push_back(gap);
            gap = 0;
         end else if (grant_o == 4'b0) begin
            gap++;
         end
         prev_g = grant_o;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_grant(output logic [3:0] g);
      for (int k = 0; k < 60 && grant_o == 4'b0; k++) tick();
      g = grant_o;
      check("wait_grant", grant_o != 4'b0, 1'b1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 60 && grant_o != 4'b0; k++) tick();
      check("wait_idle", grant_o, 4'b0);
   endtask

   task automatic serve(input int n);
      logic [3:0] g;
      for (int i = 0; i < n; i++) begin
         wait_grant(g);
         tick();
         request = request & ~g;
         wait_idle();
      end
   endtask

   task automatic do_reset();
      check("leftover_expect", exp_q.size(), 0);
      exp_q.delete();
      reset_n = 1'b0;
      request = 4'b0;
      tick();
      tick();
      check("reset_grant", grant_o, 4'b0);
      check("reset_busy", busy_o, 1'b0);
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [3:0] g;
      logic       busy_seen;
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      request  = 4'b0;
      key_bad  = 1'b0;

      // single request latency and release
      do_reset();
      request = 4'b0001;
      exp_q.push_back(4'b0001);
      tick();
      check("lat_e0", grant_o, 4'b0);
      tick();
      check("lat_e1", grant_o, 4'b0);
      tick();
      check("lat_e2_grant", grant_o, 4'b0001);
      check("lat_e2_busy", busy_o, 1'b1);
      request = 4'b0;
      tick();
      check("rel_en", grant_o, 4'b0001);
      tick();
      check("rel_en1_grant", grant_o, 4'b0);
      check("rel_en1_busy", busy_o, 1'b0);

      // simultaneous rises in ascending order, later rise behind them
      do_reset();
      gaps.delete();
      request = 4'b0101;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0010);
      tick();
      request = 4'b0111;
      serve(3);
      check("gap_count", gaps.size(), 3);
      if (gaps.size() == 3) begin
         check("gap_1", gaps[1], 2);
         check("gap_2", gaps[2], 2);
      end

      // wrong key rotates every grantee by one
      do_reset();
      key_bad = 1'b1;
      request = 4'b1111;
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0001);
      serve(4);
      key_bad = 1'b0;

      // requester 3 queued then dropped is discarded at pop
      do_reset();
      request = 4'b0001;
      exp_q.push_back(4'b0001);
      wait_grant(g);
      request = 4'b1001;
      tick();
      tick();
      request = 4'b0001;
      tick();
      request = 4'b0000;
      wait_idle();
      busy_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         busy_seen = busy_seen | busy_o;
      end
      check("discard_busy", busy_seen, 1'b0);
      request = 4'b1000;
      exp_q.push_back(4'b1000);
      serve(1);

      // asynchronous reset in the middle of a grant with three queued
      do_reset();
      request = 4'b0001;
      exp_q.push_back(4'b0001);
      wait_grant(g);
      request = 4'b1111;
      tick();
      tick();
      tick();
      check("pre_reset_grant", grant_o, 4'b0001);
      reset_n = 1'b0;
      #1;
      check("async_grant", grant_o, 4'b0);
      check("async_busy", busy_o, 1'b0);
      request = 4'b0;
      tick();
      reset_n = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         busy_seen = busy_seen | busy_o;
      end
      check("post_reset_idle", busy_seen, 1'b0);
      request = 4'b0100;
      exp_q.push_back(4'b0100);
      serve(1);

      // long holder gets one grant; others wait behind it
      do_reset();
      request = 4'b0010;
      exp_q.push_back(4'b0010);
      wait_grant(g);
      request = 4'b1011;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b1000);
      for (int i = 0; i < 20; i++) tick();
      check("hold_grant", grant_o, 4'b0010);
      request = 4'b1001;
      wait_idle();
      serve(2);
      for (int i = 0; i < 10; i++) tick();
      check("final_idle", grant_o, 4'b0);
      check("final_expect_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
